// File: rtl/pulse_peak_detector.sv
// Turns each qualified above-threshold pulse of the shaped sample stream into
// an {amplitude, peak time, width} record, buffered in a small FWFT FIFO.
module pulse_peak_detector #(
  parameter int unsigned MIN_WIDTH = 3,
  parameter int unsigned DEAD_TIME = 8,
  parameter int unsigned DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  signal_in,
  input  logic [7:0]  thr,
  input  logic        evt_ready,
  output logic        evt_valid,
  output logic [7:0]  evt_amp,
  output logic [15:0] evt_time,
  output logic [7:0]  evt_width,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned DW = 8;
  localparam int unsigned TW = 16;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [DW-1:0] amp;
    logic [TW-1:0] tpk;
    logic [DW-1:0] width;
  } rec_t;

  typedef enum logic [1:0] {IDLE, ABOVE, DEAD} state_t;

  state_t               state_q, state_n;
  logic signed [DW-1:0] thr_q, thr_n;
  logic signed [DW-1:0] max_q, max_n;
  logic [TW-1:0]        ts_q, tmax_q, tmax_n;
  logic [DW-1:0]        width_q, width_n;
  logic [DW-1:0]        dcnt_q, dcnt_n;
  logic signed [DW-1:0] sig_s;
  logic                 push_c;
  rec_t                 rec_c;

  rec_t                 ent_q [DEPTH];
  rec_t                 ent_n [DEPTH];
  logic [CW-1:0]        cnt_q, cnt_n;
  logic [AW-1:0]        wr_idx;
  logic [DW-1:0]        drop_n;
  logic                 pop_c, full_c;

  assign sig_s = $signed(signal_in);
  assign rec_c = {max_q, tmax_q, width_q};

  // Pulse tracking FSM: next state and datapath updates
  always_comb begin
    state_n = state_q;
    thr_n   = thr_q;
    max_n   = max_q;
    tmax_n  = tmax_q;
    width_n = width_q;
    dcnt_n  = dcnt_q;
    push_c  = 1'b0;
    case (state_q)
      IDLE: begin
        thr_n = $signed(thr);
        if (sig_s > $signed(thr)) begin
          state_n = ABOVE;
          max_n   = sig_s;
          tmax_n  = ts_q;
          width_n = DW'(1);
        end
      end
      ABOVE: begin
        if (sig_s > thr_q) begin
          if (width_q != {DW{1'b1}}) width_n = width_q + DW'(1);
          // Strict compare so a flat top keeps the first sample's time
          if (sig_s > max_q) begin
            max_n  = sig_s;
            tmax_n = ts_q;
          end
        end else begin
          push_c = (width_q >= DW'(MIN_WIDTH));
          if (DEAD_TIME != 0) begin
            state_n = DEAD;
            dcnt_n  = DW'(DEAD_TIME);
          end else begin
            state_n = IDLE;
          end
        end
      end
      DEAD: begin
        if (dcnt_q <= DW'(1)) state_n = IDLE;
        else                  dcnt_n  = dcnt_q - DW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop_c  = evt_valid & evt_ready;
  assign full_c = (cnt_q == CW'(DEPTH));

  // Shift-register FIFO: entry 0 is the head, unused entries are kept zero
  always_comb begin
    ent_n  = ent_q;
    cnt_n  = cnt_q;
    drop_n = drop_cnt;
    wr_idx = AW'(cnt_q);
    if (pop_c) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) ent_n[AW'(i)] = ent_q[AW'(i + 1)];
      ent_n[AW'(DEPTH - 1)] = '0;
      cnt_n  = cnt_q - CW'(1);
      wr_idx = AW'(cnt_q - CW'(1));
    end
    if (push_c) begin
      if (pop_c || !full_c) begin
        ent_n[wr_idx] = rec_c;
        cnt_n         = pop_c ? cnt_q : cnt_q + CW'(1);
      end else if (drop_cnt != {DW{1'b1}}) begin
        drop_n = drop_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      thr_q     <= '0;
      max_q     <= '0;
      tmax_q    <= '0;
      width_q   <= '0;
      dcnt_q    <= '0;
      ts_q      <= '0;
      cnt_q     <= '0;
      ent_q     <= '{default: '0};
      evt_valid <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state_q   <= state_n;
      thr_q     <= thr_n;
      max_q     <= max_n;
      tmax_q    <= tmax_n;
      width_q   <= width_n;
      dcnt_q    <= dcnt_n;
      ts_q      <= ts_q + TW'(1);
      cnt_q     <= cnt_n;
      ent_q     <= ent_n;
      evt_valid <= (cnt_n != '0);
      drop_cnt  <= drop_n;
    end
  end

  assign evt_amp   = ent_q[0].amp;
  assign evt_time  = ent_q[0].tpk;
  assign evt_width = ent_q[0].width;

endmodule
